adder_result_checker: RTL and testbench
=======================================

ADDER_RESULT_CHECKER -- requirements
Module: adder_result_checker

Interface
REQ-001 Parameter DEPTH, default 4, expected-result FIFO depth; power of two, minimum 2.
REQ-002 Parameter CNT_W, default 16, width of pass and fail counters.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 op_valid  input  1  operand beat is presented.
REQ-006 op_a, op_b  input  32 each  operands as driven to the adder DUT.
REQ-007 op_cin  input  1  carry-in as driven to the adder DUT.
REQ-008 op_ready  output  1  checker can accept an operand beat; equals FIFO not full.
REQ-009 res_valid  input  1  DUT result beat is presented.
REQ-010 res_sum  input  32  DUT Sum.
REQ-011 res_cout  input  1  DUT Cout.
REQ-012 mismatch  output  1  one-cycle pulse, compared result was wrong.
REQ-013 err_sticky  output  1  set on any mismatch or underflow; held until reset.
REQ-014 underflow  output  1  sticky; res_valid arrived while the FIFO was empty.
REQ-015 pass_cnt, fail_cnt  output  CNT_W each  count of matching and mismatching compares.
REQ-016 last_exp  output  33  {Cout,Sum} expected for the most recent compare.
REQ-017 chk_state  output  2  FSM state: 0 IDLE, 1 BUSY, 2 FAIL.

Function
REQ-018 Push rule: an operand push occurs on op_valid && op_ready.
  - Pushed entry = 33-bit {1'b0,op_a} + op_b + op_cin, computed at push time.
REQ-019 Pop rule: res_valid with the FIFO non-empty pops the oldest entry.
  - Popped entry is compared against {res_cout,res_sum} in the same cycle.
REQ-020 Compare outputs are registered one cycle after res_valid: mismatch pulse, counter increment, last_exp update.
REQ-021 A push and a pop in the same cycle are both performed; occupancy is unchanged.
REQ-022 Full FIFO: op_ready is 0; op_valid is ignored and no entry is lost or overwritten.
REQ-023 Pop with FIFO empty:
  - No compare is made and the counters are unchanged.
  - underflow and err_sticky are set on the next cycle.
  - A same-cycle push is stored but is not forwarded to that result.
REQ-024 Pointers wrap modulo DEPTH; an occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
REQ-025 FSM transitions:
  - IDLE to BUSY on a push.
  - BUSY to IDLE when occupancy reaches 0.
  - Any state to FAIL when err_sticky sets.
  - FAIL is left only by reset.
REQ-026 In FAIL, push, pop and compare continue to operate; only chk_state stays frozen.
REQ-027 res_valid and op_valid with value X are treated as 0 and do not push or pop.

Reset
REQ-028 While rst=0 at a clock edge, the following are cleared:
  - FIFO pointers and occupancy.
  - pass_cnt, fail_cnt, mismatch, underflow, err_sticky and last_exp are set to 0.
  - chk_state is set to IDLE.
  - op_ready is set to 1 on the first cycle after reset.
REQ-029 Reset asserted mid-operation discards all outstanding expected entries; a result arriving afterwards counts as underflow.
REQ-030 Push and pop are ignored during cycles in which rst=0.

Configuration
REQ-031 Macro ADDER_CHK_SAT_EN selects the counter overflow behaviour.
  - Defined: pass_cnt and fail_cnt saturate at 2^CNT_W-1.
  - Undefined: pass_cnt and fail_cnt wrap to 0 after 2^CNT_W-1.

Verification
REQ-032 Push A=2147483648, B=2147483648, Cin=0, then result Sum=0, Cout=1 -> pass_cnt=1, last_exp=0x1_0000_0000, mismatch=0.
REQ-033 Push A=12, B=12, Cin=0, then result Sum=25, Cout=0 -> mismatch pulses 1 cycle, fail_cnt=1, err_sticky=1, chk_state=FAIL.
REQ-034 Push 4 beats with DEPTH=4 and no results -> op_ready=0; fifth op_valid ignored; 4 correct results give pass_cnt=4 and chk_state=IDLE.
REQ-035 res_valid with FIFO empty -> underflow=1, err_sticky=1, pass_cnt=fail_cnt=0.
REQ-036 Push A=0, B=0, Cin=1, then assert rst=0 for one cycle, then result Sum=1 -> underflow=1 and pass_cnt=0.
REQ-037 Counter boundary, CNT_W=2, 5 correct compares:
  - With ADDER_CHK_SAT_EN defined: pass_cnt=3.
  - Without it: pass_cnt=1.

Source files
------------

// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Scoreboard for a 32-bit adder. Each accepted operand beat pushes its
//   expected 33-bit {Cout,Sum} into a small FIFO. Each result beat pops the
//   oldest entry and compares it against the DUT output. Compare outputs
//   (mismatch pulse, counters, last_exp) appear one cycle after res_valid.
//
// Parameters
//   DEPTH  expected-result FIFO depth (power of two, >= 2)
//   CNT_W  width of pass_cnt / fail_cnt
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   op_valid/op_ready   operand beat handshake (op_ready = FIFO not full)
//   op_a, op_b, op_cin  operands as driven to the adder
//   res_valid           result beat strobe
//   res_sum, res_cout   adder result
//   mismatch            one-cycle pulse on a wrong result
//   err_sticky          any mismatch or underflow, held until reset
//   underflow           sticky, result arrived with FIFO empty
//   pass_cnt, fail_cnt  compare counters
//   last_exp            expected {Cout,Sum} of the most recent compare
//   chk_state           0 IDLE, 1 BUSY, 2 FAIL
//
// Build option
//   ADDER_CHK_SAT_EN    defined: counters saturate; undefined: counters wrap
module adder_result_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [31:0]      op_a,
  input  logic [31:0]      op_b,
  input  logic             op_cin,
  output logic             op_ready,
  input  logic             res_valid,
  input  logic [31:0]      res_sum,
  input  logic             res_cout,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             underflow,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [32:0]      last_exp,
  output logic [1:0]       chk_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  logic [32:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mismatch_q, mismatch_d;
  logic             err_sticky_q, err_sticky_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [32:0]      last_exp_q, last_exp_d;
  state_t           state_q, state_d;

  logic        op_v, res_v;
  logic        full, empty;
  logic        push, pop, under;
  logic [32:0] push_data, pop_data, res_word;
  logic        match;

  // Case-equality turns an X strobe into "not valid" in simulation.
  assign op_v  = (op_valid === 1'b1);
  assign res_v = (res_valid === 1'b1);

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign op_ready = ~full;

  assign push  = rst & op_v & ~full;
  assign pop   = rst & res_v & ~empty;
  // A push in the same cycle as an empty pop is stored but never forwarded.
  assign under = rst & res_v & empty;

  assign push_data = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_cin};
  assign pop_data  = mem_q[rd_ptr_q];
  assign res_word  = {res_cout, res_sum};
  assign match     = (pop_data == res_word);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    underflow_d  = underflow_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    last_exp_d   = last_exp_q;
    state_d      = state_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (pop) begin
      last_exp_d = pop_data;
      if (match) begin
`ifdef ADDER_CHK_SAT_EN
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
`else
        pass_cnt_d = pass_cnt_q + 1'b1;
`endif
      end else begin
        mismatch_d   = 1'b1;
        err_sticky_d = 1'b1;
`ifdef ADDER_CHK_SAT_EN
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
`else
        fail_cnt_d = fail_cnt_q + 1'b1;
`endif
      end
    end

    if (under) begin
      underflow_d  = 1'b1;
      err_sticky_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: if (push) state_d = ST_BUSY;
      ST_BUSY: if (count_d == '0) state_d = ST_IDLE;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_IDLE;
    endcase
    // FAIL is entered together with err_sticky rising and never left.
    if (err_sticky_d) state_d = ST_FAIL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      underflow_q  <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      last_exp_q   <= '0;
      state_q      <= ST_IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      underflow_q  <= underflow_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      last_exp_q   <= last_exp_d;
      state_q      <= state_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign underflow  = underflow_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign last_exp   = last_exp_q;
  assign chk_state  = state_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker. A default-sized instance and a
// CNT_W=2 instance share all stimulus; the small one exercises the counter
// overflow behaviour selected by ADDER_CHK_SAT_EN.
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [31:0] op_a, op_b;
  logic        op_cin;
  logic        res_valid;
  logic [31:0] res_sum;
  logic        res_cout;

  logic        op_ready, mismatch, err_sticky, underflow;
  logic [15:0] pass_cnt, fail_cnt;
  logic [32:0] last_exp;
  logic [1:0]  chk_state;

  logic        d2_op_ready, d2_mismatch, d2_err_sticky, d2_underflow;
  logic [1:0]  d2_pass_cnt, d2_fail_cnt;
  logic [32:0] d2_last_exp;
  logic [1:0]  d2_chk_state;

  int vectors = 0;
  int miscompares = 0;

`ifdef ADDER_CHK_SAT_EN
  localparam logic [1:0] D2_PASS_AFTER5 = 2'd3;
`else
  localparam logic [1:0] D2_PASS_AFTER5 = 2'd1;
`endif

  always #5 clk = ~clk;

  adder_result_checker #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_ready(op_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout),
    .mismatch(mismatch), .err_sticky(err_sticky), .underflow(underflow),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .last_exp(last_exp),
    .chk_state(chk_state)
  );

  adder_result_checker #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .op_ready(d2_op_ready),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout),
    .mismatch(d2_mismatch), .err_sticky(d2_err_sticky), .underflow(d2_underflow),
    .pass_cnt(d2_pass_cnt), .fail_cnt(d2_fail_cnt), .last_exp(d2_last_exp),
    .chk_state(d2_chk_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic c);
    op_valid = 1'b1; op_a = a; op_b = b; op_cin = c;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic result(input logic [31:0] s, input logic c);
    res_valid = 1'b1; res_sum = s; res_cout = c;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    res_valid = 1'b0; res_sum = '0; res_cout = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // reset state
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_pass", 64'(pass_cnt), 64'd0);
    chk("rst_fail", 64'(fail_cnt), 64'd0);
    chk("rst_flags", 64'({mismatch, underflow, err_sticky}), 64'd0);
    chk("rst_last", 64'(last_exp), 64'd0);
    chk("rst_state", 64'(chk_state), 64'd0);

    // 0x80000000 + 0x80000000 = 0x1_0000_0000
    push(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("carry_busy", 64'(chk_state), 64'd1);
    result(32'h0, 1'b1);
    chk("carry_pass", 64'(pass_cnt), 64'd1);
    chk("carry_last", 64'(last_exp), 64'h1_0000_0000);
    chk("carry_mm", 64'(mismatch), 64'd0);
    chk("carry_idle", 64'(chk_state), 64'd0);

    // 12 + 12 = 24, DUT claims 25
    push(32'd12, 32'd12, 1'b0);
    result(32'd25, 1'b0);
    chk("bad_mm", 64'(mismatch), 64'd1);
    chk("bad_fail", 64'(fail_cnt), 64'd1);
    chk("bad_err", 64'(err_sticky), 64'd1);
    chk("bad_state", 64'(chk_state), 64'd2);
    chk("bad_last", 64'(last_exp), 64'd24);
    tick();
    chk("bad_mm_pulse", 64'(mismatch), 64'd0);
    chk("bad_state_hold", 64'(chk_state), 64'd2);

    // fill to DEPTH, overflow attempt, then drain in order
    do_reset();
    chk("rst2_state", 64'(chk_state), 64'd0);
    push(32'd1, 32'd2, 1'b0);
    push(32'd3, 32'd4, 1'b1);
    push(32'd100, 32'd200, 1'b0);
    push(32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("full_ready", 64'(op_ready), 64'd0);
    push(32'd5, 32'd5, 1'b0);
    chk("full_ready2", 64'(op_ready), 64'd0);
    result(32'd3, 1'b0);
    result(32'd8, 1'b0);
    result(32'd300, 1'b0);
    result(32'h0000_0001, 1'b1);
    chk("drain_pass", 64'(pass_cnt), 64'd4);
    chk("drain_fail", 64'(fail_cnt), 64'd0);
    chk("drain_state", 64'(chk_state), 64'd0);
    chk("drain_ready", 64'(op_ready), 64'd1);
    chk("drain_last", 64'(last_exp), 64'h1_0000_0001);

    // fifth compare: CNT_W=2 instance wraps or saturates
    push(32'd7, 32'd8, 1'b0);
    result(32'd15, 1'b0);
    chk("five_pass", 64'(pass_cnt), 64'd5);
    chk("cnt2_pass", 64'(d2_pass_cnt), 64'(D2_PASS_AFTER5));

    // simultaneous push and pop keeps occupancy
    push(32'd10, 32'd20, 1'b0);
    op_valid = 1'b1; op_a = 32'd1; op_b = 32'd1; op_cin = 1'b0;
    res_valid = 1'b1; res_sum = 32'd30; res_cout = 1'b0;
    tick();
    op_valid = 1'b0; res_valid = 1'b0;
    chk("both_pass", 64'(pass_cnt), 64'd6);
    chk("both_busy", 64'(chk_state), 64'd1);
    result(32'd2, 1'b0);
    chk("both_pass2", 64'(pass_cnt), 64'd7);
    chk("both_idle", 64'(chk_state), 64'd0);

    // result with empty FIFO
    do_reset();
    result(32'd0, 1'b0);
    chk("uf_flag", 64'(underflow), 64'd1);
    chk("uf_err", 64'(err_sticky), 64'd1);
    chk("uf_cnts", 64'({pass_cnt, fail_cnt}), 64'd0);
    chk("uf_mm", 64'(mismatch), 64'd0);
    chk("uf_state", 64'(chk_state), 64'd2);

    // X strobes do nothing
    do_reset();
    op_valid = 1'bx;
    tick();
    op_valid = 1'b0;
    chk("x_op_state", 64'(chk_state), 64'd0);
    res_valid = 1'bx;
    tick();
    res_valid = 1'b0;
    chk("x_res_uf", 64'(underflow), 64'd0);
    result(32'd0, 1'b0);
    chk("x_op_nopush", 64'(underflow), 64'd1);

    // reset discards outstanding entry
    do_reset();
    push(32'd0, 32'd0, 1'b1);
    do_reset();
    chk("mid_rst_state", 64'(chk_state), 64'd0);
    result(32'd1, 1'b0);
    chk("mid_rst_uf", 64'(underflow), 64'd1);
    chk("mid_rst_pass", 64'(pass_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
